// File: rtl/pwm_multi_if.sv
// Control/status bundle for the multi-channel PWM generator.
// The register/control side uses the master modport, the PWM core uses slave.
interface pwm_multi_if #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int PRESC_WIDTH = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                   enable;
    logic [PRESC_WIDTH-1:0] prescale;
    logic                   center_mode;
    logic                   duty_wr;
    logic [CH_W-1:0]        duty_ch;
    logic [WIDTH-1:0]       duty_val;
    logic [CHANNELS-1:0]    pwm_out;
    logic                   period_start;

    modport master (
        output enable, prescale, center_mode, duty_wr, duty_ch, duty_val,
        input  pwm_out, period_start
    );

    modport slave (
        input  enable, prescale, center_mode, duty_wr, duty_ch, duty_val,
        output pwm_out, period_start
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared prescaled period counter, edge/center
// alignment and double-buffered duty registers that only load at a period boundary.
module pwm_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int PRESC_WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    pwm_multi_if.slave bus
);
    localparam int               CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] MAX  = '1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRESC_WIDTH-1:0] r_pre_cnt;
    logic [WIDTH-1:0]       r_cnt;
    dir_t                   r_dir;
    logic                   r_mode_act;
    logic [WIDTH-1:0]       r_duty_sh  [CHANNELS];
    logic [WIDTH-1:0]       r_duty_act [CHANNELS];
    logic [CHANNELS-1:0]    r_pwm_out;
    logic                   r_period_start;

    logic                   w_tick;
    logic                   w_boundary;
    logic [WIDTH-1:0]       w_cnt_next;
    dir_t                   w_dir_next;

    assign w_tick     = bus.enable && (r_pre_cnt == bus.prescale);
    assign w_boundary = w_tick && (w_cnt_next == '0);

    // Next count/direction; center mode turns around as soon as a limit is reached
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        if (!r_mode_act) begin
            w_cnt_next = r_cnt + 1'b1;
            w_dir_next = DIR_UP;
        end else if (r_dir == DIR_UP) begin
            w_cnt_next = r_cnt + 1'b1;
            if (w_cnt_next == MAX) begin
                w_dir_next = DIR_DOWN;
            end
        end else begin
            w_cnt_next = r_cnt - 1'b1;
            if (w_cnt_next == '0) begin
                w_dir_next = DIR_UP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt      <= '0;
            r_cnt          <= '0;
            r_dir          <= DIR_UP;
            r_mode_act     <= 1'b0;
            r_period_start <= 1'b0;
        end else if (!bus.enable) begin
            r_pre_cnt      <= '0;
            r_cnt          <= '0;
            r_dir          <= DIR_UP;
            r_mode_act     <= bus.center_mode;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;
            if (w_tick) begin
                r_pre_cnt <= '0;
                r_cnt     <= w_cnt_next;
                r_dir     <= w_boundary ? DIR_UP : w_dir_next;
                if (w_boundary) begin
                    r_mode_act <= bus.center_mode;
                end
            end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
        end
    end

    // Active duties copy the pre-write shadow, so a write on the boundary lands one period later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_sh[i]  <= '0;
                r_duty_act[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.duty_wr && (bus.duty_ch == CH_W'(i))) begin
                    r_duty_sh[i] <= bus.duty_val;
                end
                if (!bus.enable || w_boundary) begin
                    r_duty_act[i] <= r_duty_sh[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_out <= '0;
        end else if (!bus.enable) begin
            r_pwm_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_pwm_out[i] <= (r_cnt < r_duty_act[i]);
            end
        end
    end

    assign bus.pwm_out      = r_pwm_out;
    assign bus.period_start = r_period_start;
endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus a randomized run,
// all compared cycle by cycle against a position-in-period reference model.
module tb_pwm_multi;
    localparam int CHANNELS    = 4;
    localparam int WIDTH       = 8;
    localparam int PRESC_WIDTH = 8;
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MAXV        = (1 << WIDTH) - 1;
    localparam int PRESC_MOD   = 1 << PRESC_WIDTH;

    logic clk = 1'b0;
    logic rst_n;

    pwm_multi_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .PRESC_WIDTH(PRESC_WIDTH)) bus ();

    pwm_multi #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .PRESC_WIDTH(PRESC_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: tick position inside the period, mode, and duty copies
    int                  mPre;
    int                  mPos;
    bit                  mMode;
    int                  mSh  [CHANNELS];
    int                  mAct [CHANNELS];
    logic [CHANNELS-1:0] expPwm;
    logic                expPs;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int periodLen(input bit mode);
        return mode ? 2 * MAXV : MAXV + 1;
    endfunction

    function automatic int cntOf(input int pos, input bit mode);
        if (!mode || pos <= MAXV) return pos;
        return 2 * MAXV - pos;
    endfunction

    function automatic bit modelBoundaryNext();
        return bus.enable && (mPre == int'(bus.prescale)) && (mPos + 1 == periodLen(mMode));
    endfunction

    task automatic modelReset();
        mPre   = 0;
        mPos   = 0;
        mMode  = 1'b0;
        expPwm = '0;
        expPs  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            mSh[i]  = 0;
            mAct[i] = 0;
        end
    endtask

    task automatic modelStep();
        int curCnt;
        if (rst_n !== 1'b1) begin
            modelReset();
            return;
        end
        if (!bus.enable) begin
            expPwm = '0;
            expPs  = 1'b0;
            mPre   = 0;
            mPos   = 0;
            mMode  = bus.center_mode;
            for (int i = 0; i < CHANNELS; i++) mAct[i] = mSh[i];
        end else begin
            curCnt = cntOf(mPos, mMode);
            for (int i = 0; i < CHANNELS; i++) expPwm[i] = (curCnt < mAct[i]);
            expPs = 1'b0;
            if (mPre == int'(bus.prescale)) begin
                mPre = 0;
                mPos++;
                if (mPos == periodLen(mMode)) begin
                    mPos = 0;
                    for (int i = 0; i < CHANNELS; i++) mAct[i] = mSh[i];
                    mMode = bus.center_mode;
                    expPs = 1'b1;
                end
            end else begin
                mPre = (mPre + 1) % PRESC_MOD;
            end
        end
        if (bus.duty_wr && int'(bus.duty_ch) < CHANNELS) mSh[bus.duty_ch] = int'(bus.duty_val);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("pwm_out", 32'(bus.pwm_out), 32'(expPwm));
        checkOutput("period_start", 32'(bus.period_start), 32'(expPs));
    endtask

    task automatic applyStimulus(input int ch, input int val);
        bus.duty_wr  = 1'b1;
        bus.duty_ch  = CH_W'(ch);
        bus.duty_val = WIDTH'(val);
        stepCycle();
        bus.duty_wr  = 1'b0;
    endtask

    task automatic waitPeriodStart(input int budget, output int n);
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (bus.period_start !== 1'b1 && n < budget);
        checkOutput("periodStartSeen", 32'(bus.period_start), 32'd1);
    endtask

    task automatic measureWindow(input int ch, input int len, output int highs, output int starts);
        highs  = 0;
        starts = 0;
        for (int k = 0; k < len; k++) begin
            stepCycle();
            highs  += int'(bus.pwm_out[ch]);
            starts += int'(bus.period_start);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n, highs, starts, guard;
        rst_n           = 1'b1;
        bus.enable      = 1'b0;
        bus.prescale    = '0;
        bus.center_mode = 1'b0;
        bus.duty_wr     = 1'b0;
        bus.duty_ch     = '0;
        bus.duty_val    = '0;
        modelReset();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("resetPwm", 32'(bus.pwm_out), 32'd0);
        checkOutput("resetPs", 32'(bus.period_start), 32'd0);
        stepCycle();
        stepCycle();
        rst_n      = 1'b1;
        bus.enable = 1'b1;

        // Edge mode, duty 64
        applyStimulus(0, 64);
        waitPeriodStart(600, n);
        waitPeriodStart(600, n);
        checkOutput("edgeSpacing", n, 256);
        measureWindow(0, 256, highs, starts);
        checkOutput("edgeHigh64", highs, 64);
        checkOutput("edgeStarts", starts, 1);

        // Duty extremes
        applyStimulus(1, 0);
        applyStimulus(2, MAXV);
        waitPeriodStart(600, n);
        measureWindow(1, 256, highs, starts);
        checkOutput("dutyZeroHigh", highs, 0);
        measureWindow(2, 256, highs, starts);
        checkOutput("dutyMaxHigh", highs, 255);

        // Prescale 3, duty 128
        bus.prescale = 8'd3;
        applyStimulus(0, 128);
        waitPeriodStart(2100, n);
        waitPeriodStart(2100, n);
        checkOutput("prescSpacing", n, 1024);
        measureWindow(0, 1024, highs, starts);
        checkOutput("prescHigh", highs, 512);
        checkOutput("prescStarts", starts, 1);

        // Shadow update mid-period and on the boundary cycle
        bus.prescale = 8'd0;
        applyStimulus(0, 50);
        waitPeriodStart(2100, n);
        waitPeriodStart(600, n);
        highs = 0;
        for (int k = 0; k < 256; k++) begin
            if (k == 100) begin
                bus.duty_wr  = 1'b1;
                bus.duty_ch  = CH_W'(0);
                bus.duty_val = WIDTH'(200);
            end
            stepCycle();
            bus.duty_wr = 1'b0;
            highs += int'(bus.pwm_out[0]);
        end
        checkOutput("shadowKeepOld", highs, 50);
        measureWindow(0, 256, highs, starts);
        checkOutput("shadowNew", highs, 200);
        guard = 0;
        while (!modelBoundaryNext() && guard < 600) begin
            stepCycle();
            guard++;
        end
        applyStimulus(0, 10);
        checkOutput("boundaryWritePs", 32'(bus.period_start), 32'd1);
        measureWindow(0, 256, highs, starts);
        checkOutput("boundaryWriteOld", highs, 200);
        measureWindow(0, 256, highs, starts);
        checkOutput("boundaryWriteNew", highs, 10);

        // Center mode, switched mid-period
        applyStimulus(3, 100);
        waitPeriodStart(600, n);
        bus.center_mode = 1'b1;
        for (int k = 0; k < 50; k++) stepCycle();
        waitPeriodStart(600, n);
        checkOutput("modeSwitchAtBoundary", n, 206);
        waitPeriodStart(600, n);
        checkOutput("centerSpacing", n, 510);
        measureWindow(3, 510, highs, starts);
        checkOutput("centerHigh", highs, 199);
        checkOutput("centerStarts", starts, 1);

        // Asynchronous reset in the middle of a pulse
        bus.center_mode = 1'b0;
        applyStimulus(0, 128);
        waitPeriodStart(600, n);
        waitPeriodStart(600, n);
        for (int k = 0; k < 10; k++) stepCycle();
        checkOutput("prePulseHigh", 32'(bus.pwm_out[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstPwm", 32'(bus.pwm_out), 32'd0);
        checkOutput("asyncRstPs", 32'(bus.period_start), 32'd0);
        modelReset();
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) stepCycle();

        // Drop and restore enable mid-period
        applyStimulus(0, 128);
        waitPeriodStart(600, n);
        for (int k = 0; k < 60; k++) stepCycle();
        bus.enable = 1'b0;
        for (int k = 0; k < 5; k++) stepCycle();
        checkOutput("disabledPwm", 32'(bus.pwm_out), 32'd0);
        bus.enable = 1'b1;
        measureWindow(0, 255, highs, starts);
        checkOutput("reenableNoPs", starts, 0);
        checkOutput("reenableHigh", highs, 128);
        stepCycle();
        checkOutput("reenableFirstPs", 32'(bus.period_start), 32'd1);

        // Randomized traffic
        for (int c = 0; c < 8000; c++) begin
            bus.duty_wr = ($urandom_range(0, 7) == 0);
            bus.duty_ch = CH_W'($urandom_range(0, CHANNELS - 1));
            case ($urandom_range(0, 3))
                0:       bus.duty_val = '0;
                1:       bus.duty_val = '1;
                default: bus.duty_val = WIDTH'($urandom);
            endcase
            if (bus.enable && $urandom_range(0, 499) == 0) bus.enable = 1'b0;
            else if (!bus.enable && $urandom_range(0, 19) == 0) bus.enable = 1'b1;
            if ($urandom_range(0, 299) == 0) bus.center_mode = ~bus.center_mode;
            if ($urandom_range(0, 699) == 0) bus.prescale = PRESC_WIDTH'($urandom_range(0, 2));
            stepCycle();
        end
        bus.duty_wr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM generator for dimming and brightness control of LEDs and tail lights. It drives CHANNELS outputs from one shared period counter with a programmable prescaler. Each output has a double-buffered duty register, so a new duty value only takes effect at a period boundary and never produces a glitched pulse. It supports edge-aligned (sawtooth) and center-aligned (triangle) counting, and sits between the register/control logic and the output pins.

## Interface
- CHANNELS, 4: number of PWM outputs (≥1).
- WIDTH, 8: counter and duty width; MAX = 2^WIDTH − 1.
- PRESC_WIDTH, 8: prescaler reload width.
- CH_W, derived: max(1, clog2(CHANNELS)); width of the channel index.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run when 1; when 0, counters are held cleared and outputs are 0.
- prescale  in  PRESC_WIDTH  a counter tick occurs every prescale+1 clk cycles.
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled only at period load.
- duty_wr  in  1  write strobe for one shadow duty register.
- duty_ch  in  CH_W  target channel; writes with duty_ch ≥ CHANNELS are ignored.
- duty_val  in  WIDTH  duty value to write.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  one-cycle pulse when a new period begins and active duties load.

## Operation
- State:
  - pre_cnt: prescaler counter.
  - cnt: WIDTH-bit period counter.
  - dir: 0 = up, 1 = down.
  - mode_act: latched counting mode.
  - duty_sh[CHANNELS]: shadow duty registers.
  - duty_act[CHANNELS]: active duty registers.
- Shadow write: when duty_wr=1, duty_sh[duty_ch] ← duty_val. This happens regardless of enable.
- tick = enable ∧ (pre_cnt == prescale).
  - Otherwise, when enabled, pre_cnt increments.
  - When tick, pre_cnt ← 0.
- Edge mode (mode_act=0): on each tick, cnt counts 0,1,…,MAX, then wraps to 0. The period is MAX+1 ticks.
- Center mode (mode_act=1):
  - On each tick, cnt counts 0→MAX going up, then MAX−1→1 going down, then returns to 0.
  - dir flips when cnt reaches MAX (to down) and when cnt reaches 0 (to up).
  - The period is 2·MAX ticks.
- boundary = tick ∧ (next cnt == 0). At boundary:
  - duty_act[i] ← duty_sh[i] for all channels.
  - mode_act ← center_mode.
  - dir ← up.
  - period_start ← 1 for one cycle; it is 0 at all other times.
- Output, evaluated every cycle while enabled: pwm_out[i] ← (cnt < duty_act[i]), an unsigned compare.
  - Edge mode: duty 0 gives a constant low; duty D gives D high ticks out of MAX+1.
  - Center mode: duty D>0 gives 2·D−1 high ticks out of 2·MAX, centred on cnt=0; duty 0 gives a constant low.
- enable=0:
  - pre_cnt, cnt and dir are cleared.
  - pwm_out and period_start are 0.
  - duty_act continuously follows duty_sh, and mode_act follows center_mode.
  - When enable returns to 1, counting starts at cnt=0 with no period_start pulse for that first period.
- Simultaneous write and boundary in the same cycle: duty_sh takes the new value, but duty_act loads the old shadow value. The new value applies from the following period, with no forwarding.
- Changing prescale mid-period takes effect immediately on the compare. If pre_cnt > prescale, pre_cnt keeps counting up and wraps at 2^PRESC_WIDTH before a tick occurs.

## Timing
- Reset (rst_n=0, asynchronous) clears:
  - pre_cnt, cnt, dir and mode_act to 0.
  - All duty_sh and duty_act registers to 0.
  - pwm_out to 0 and period_start to 0.
  - Release of reset is synchronous to clk; the first count occurs on the first tick after release.
- Reset mid-period forces all outputs low immediately, with no completion of the current pulse.
- pwm_out lags cnt by 1 clk, because it is a registered compare against the current cnt.
- period_start is asserted in the same clk cycle in which cnt=0 and the new duty_act are first visible.
- A duty write becomes effective on pwm_out at the latest 1 clk after the next period_start.

## Test plan
- Edge, prescale=0, ch0 duty=64, WIDTH=8 -> pwm_out[0] is 64 cycles high and 192 low, repeating every 256 cycles; period_start pulses every 256 cycles.
- Duty extremes, edge mode, ch1=0, ch2=255 -> ch1 is never high; ch2 is 255 high and 1 low per 256 cycles; no glitches across the wrap.
- Prescale=3, ch0 duty=128 -> period is 1024 clk and high time is 512 clk; period_start is spaced 1024 cycles apart.
- Shadow update: write ch0=200 at mid-period while the active duty is 50 -> the current period keeps 50 high ticks; the next period has 200. Also issue a write on the boundary cycle -> it takes effect one period later.
- Center mode, ch3 duty=100, prescale=0 -> period is 510 cycles and the high pulse is 199 cycles, centred on cnt=0. Set center_mode mid-period -> the switch happens only at the next period_start.
- Reset/enable: assert rst_n=0 mid-pulse -> pwm_out=0 asynchronously and all registers clear. Drop enable mid-period -> outputs go to 0 and cnt goes to 0; re-enable -> the count restarts at 0 with no period_start for the first period.
